setpoint_ramp: RTL and testbench
================================

# setpoint_ramp

Slew-rate limiter and direction sequencer that sits directly upstream of the motor control top level and drives its `i_setPoint`, `i_dir` and `i_motor_en` inputs. It accepts a signed target RPM from the host, moves the commanded setpoint toward it by a fixed RPM step once per control tick, and handles sign reversals safely. On a reversal it ramps to zero, holds zero for a dwell period, flips direction, then ramps out. This keeps the PI loop and H-bridge free of step demands and instantaneous reversals.

## Interface
- `TICK_CYCLES`, default 1_000_000: clock cycles per ramp tick (10 ms at 10 ns clock); minimum 2.
- `DWELL_TICKS`, default 20: ticks held at zero setpoint before a direction flip; minimum 1.
- `i_clk`  in  1  system clock; the only clock.
- `i_rstn`  in  1  reset; asynchronous and active-low.
- `i_enable`  in  1  ramp/motor enable.
- `i_target`  in  32  target RPM, signed two's complement.
- `i_target_valid`  in  1  single-cycle strobe; captures `i_target`.
- `i_step`  in  16  RPM change per tick, unsigned; 0 = bypass (jump).
- `o_setpoint`  out  32  ramped signed setpoint; connects to `i_setPoint`.
- `o_dir`  out  1  '0' forwards, '1' backwards; connects to `i_dir`.
- `o_motor_en`  out  1  motor driver enable.
- `o_busy`  out  1  state ≠ IDLE.
- `o_at_target`  out  1  `o_setpoint == target_r` and state ≠ DWELL.

## Operation
- **Reset values** (asynchronous):
  - `o_setpoint`=0, `o_dir`=0, `o_motor_en`=0, `o_busy`=0, `o_at_target`=1.
  - `target_r`=0, tick counter=0, dwell counter=0, state IDLE.
- **Target capture:** `i_target_valid` loads `target_r` in any state while enabled. The latest strobe wins. The strobe is ignored while `i_enable`=0.
- **Tick generation:**
  - The counter counts 0..`TICK_CYCLES`-1; the tick fires when the count equals `TICK_CYCLES`-1.
  - The counter clears on disable.
  - The counter clears on a target capture while in IDLE.
- **IDLE**
  - On a capture with new `target_r` ≠ `o_setpoint`, go to RAMP.
  - If `o_setpoint`=0, set `o_dir` ← sign of new target in the same cycle (no dwell when starting from zero).
- **RAMP**, on each tick:
  - *Opposing sign* (`o_setpoint` ≠ 0 and its sign ≠ sign of `target_r`, or `target_r`=0): move toward 0 by `i_step`, clamped at 0.
    - On reaching 0 with `target_r` ≠ 0 and a sign change required, go to DWELL.
    - On reaching 0 with `target_r`=0, go to IDLE.
  - *Otherwise*: move toward `target_r` by `i_step`, clamped at `target_r`. On equality, go to IDLE.
  - `i_step`=0: the setpoint jumps to the clamp value of the current leg in one tick. Reversal still passes through DWELL.
- **DWELL**
  - `o_setpoint` is held at 0; the dwell counter increments per tick.
  - After `DWELL_TICKS` ticks: `o_dir` ← `target_r[31]`, go to RAMP. The first nonzero step occurs on the following tick.
  - Capture with sign equal to current `o_dir`: abort dwell, `o_dir` unchanged, go to RAMP.
  - Capture of 0: go to IDLE.
- **Arithmetic:**
  - Step math uses 33-bit signed intermediates: setpoint ± zero-extended `i_step`.
  - Clamp against `target_r` or 0 before truncation to 32 bits. No wrap is possible for any target in [-2^31, 2^31-1].
- **Disable** (`i_enable`=0): on the next clock, `o_setpoint`=0, `o_motor_en`=0, state IDLE, counters cleared. `target_r` and `o_dir` are retained.
- **Re-enable:** a new capture is required to ramp from 0.
- `o_motor_en` is `i_enable` registered one cycle.

## Timing
- All outputs are registered.
- Capture-to-first-step: exactly `TICK_CYCLES` cycles from the capture cycle, when in IDLE.
- Within RAMP, a capture affects the next tick; there is no tick realignment.
- The setpoint updates one cycle after the tick condition.
- `o_busy` and `o_at_target` update in the same cycle as the state/setpoint change.
- Reversal from +S to negative target T with step k:
  - ceil(S/k) ticks down to 0,
  - then `DWELL_TICKS` ticks,
  - then ceil(|T|/k) ticks out.
- A capture in the same cycle as a tick: the tick uses the old `target_r`.
- A disable in the same cycle as a tick or capture: disable wins.

## Test plan
Bench uses `TICK_CYCLES`=4, `DWELL_TICKS`=2.
- **Reset:** assert `i_rstn`=0 mid-ramp, asynchronously → all outputs at reset values immediately, `o_at_target`=1.
- **Ramp up:** enable, step 100, target 250 → setpoint 100, 200, 250 at 4-cycle spacing, first at capture+4. `o_busy` falls and `o_at_target` rises with 250. `o_dir`=0.
- **Reversal:** from 250, target -150, step 100 → 150, 50, 0; then 2 ticks at 0 with `o_at_target`=0; `o_dir`→1; then -100, -150.
- **Dwell abort:** during dwell after the reversal above, capture +80 → `o_dir` stays 0, next tick setpoint 80, IDLE.
- **Disable mid-ramp:** at setpoint 200 drop `i_enable` → next cycle setpoint 0, `o_motor_en`=0, `o_busy`=0. Re-enable plus capture 300 ramps from 0.
- **Extremes/bypass:** from 0, step 0xFFFF, target -2^31 → monotonic decrease, no wrap, final exactly 0x80000000. Step 0, target 500 → 500 in one tick.

Source files
------------

// File: rtl/setpoint_ramp_if.sv
// setpoint_ramp_if
// Host-side command bus of the setpoint ramp plus the ramped outputs that feed
// the motor control top level.
//   i_enable        ramp/motor enable
//   i_target        signed target RPM
//   i_target_valid  single-cycle strobe that captures i_target
//   i_step          unsigned RPM change per tick (0 = jump)
//   o_setpoint      ramped signed setpoint
//   o_dir           0 forwards, 1 backwards
//   o_motor_en      registered copy of i_enable
//   o_busy          ramp engine not idle
//   o_at_target     setpoint equals target and not dwelling
// master: the host side, slave: the ramp engine.
interface setpoint_ramp_if;
  logic               i_enable;
  logic signed [31:0] i_target;
  logic               i_target_valid;
  logic [15:0]        i_step;
  logic signed [31:0] o_setpoint;
  logic               o_dir;
  logic               o_motor_en;
  logic               o_busy;
  logic               o_at_target;

  modport master (
    output i_enable, i_target, i_target_valid, i_step,
    input  o_setpoint, o_dir, o_motor_en, o_busy, o_at_target
  );

  modport slave (
    input  i_enable, i_target, i_target_valid, i_step,
    output o_setpoint, o_dir, o_motor_en, o_busy, o_at_target
  );
endinterface

// File: rtl/setpoint_ramp.sv
// setpoint_ramp
// Slew-rate limiter and direction sequencer in front of the motor controller.
// The commanded setpoint moves toward the captured target by i_step once per
// tick. A sign reversal ramps to zero, holds zero for DWELL_TICKS ticks, flips
// the direction output, then ramps out.
// Parameters:
//   TICK_CYCLES  clock cycles per ramp tick (>= 2)
//   DWELL_TICKS  ticks held at zero before a direction flip (>= 1)
// Ports:
//   i_clk   system clock
//   i_rstn  asynchronous active-low reset
//   bus     setpoint_ramp_if.slave (command inputs, ramped outputs)
module setpoint_ramp #(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int DWELL_TICKS = 20
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  setpoint_ramp_if.slave  bus
);

  localparam int TICK_W  = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam int DWELL_W = $clog2(DWELL_TICKS + 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic signed [32:0] ZERO33     = '0;

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_DWELL} state_t;

  state_t              state_reg, state_next;
  logic signed [31:0]  setpoint_reg, setpoint_next;
  logic signed [31:0]  target_reg, target_next;
  logic                dir_reg, dir_next;
  logic                motor_en_reg;
  logic                busy_reg, busy_next;
  logic                at_target_reg, at_target_next;
  logic [TICK_W-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [DWELL_W-1:0]  dwell_cnt_reg, dwell_cnt_next;

  logic                capture;
  logic                tick;

  // One-step arithmetic for the current leg
  logic signed [32:0]  sp_ext, tgt_ext, step_ext, up_sum, dn_sum;
  logic                step_zero;
  logic                leg_opposing;
  logic signed [31:0]  leg_value;

  assign capture = bus.i_enable & bus.i_target_valid;
  assign tick    = (tick_cnt_reg == TICK_LAST);

  // Leg value: one step toward zero when the setpoint opposes the target (or
  // the target is zero), otherwise one step toward the target. Sums are 33 bits
  // wide so the clamp is decided before truncation and nothing can wrap.
  always_comb begin
    sp_ext       = {setpoint_reg[31], setpoint_reg};
    tgt_ext      = {target_reg[31], target_reg};
    step_ext     = {17'd0, bus.i_step};
    up_sum       = sp_ext + step_ext;
    dn_sum       = sp_ext - step_ext;
    step_zero    = (bus.i_step == 16'd0);
    leg_opposing = ((setpoint_reg != '0) && (setpoint_reg[31] != target_reg[31]))
                   || (target_reg == '0);
    leg_value    = '0;
    if (leg_opposing) begin
      if (setpoint_reg[31]) begin
        leg_value = (step_zero || (up_sum >= ZERO33)) ? '0 : up_sum[31:0];
      end else begin
        leg_value = (step_zero || (dn_sum <= ZERO33)) ? '0 : dn_sum[31:0];
      end
    end else begin
      if (tgt_ext > sp_ext) begin
        leg_value = (step_zero || (up_sum >= tgt_ext)) ? target_reg : up_sum[31:0];
      end else begin
        leg_value = (step_zero || (dn_sum <= tgt_ext)) ? target_reg : dn_sum[31:0];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    setpoint_next  = setpoint_reg;
    target_next    = capture ? bus.i_target : target_reg;
    dir_next       = dir_reg;
    dwell_cnt_next = dwell_cnt_reg;
    tick_cnt_next  = tick ? '0 : tick_cnt_reg + TICK_W'(1);

    if (!bus.i_enable) begin
      // Disable dominates any tick or capture in the same cycle.
      state_next     = ST_IDLE;
      setpoint_next  = '0;
      tick_cnt_next  = '0;
      dwell_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (capture) begin
            // Realign the tick so the first step lands TICK_CYCLES later.
            tick_cnt_next = '0;
            if (bus.i_target != setpoint_reg) begin
              state_next = ST_RAMP;
              if (setpoint_reg == '0) begin
                dir_next = bus.i_target[31];
              end
            end
          end
        end

        ST_RAMP: begin
          if (tick) begin
            if ((setpoint_reg == '0) && (target_reg != '0) &&
                (target_reg[31] != dir_reg)) begin
              // Sitting at zero but pointed the wrong way (target changed sign
              // before the first step): take the dwell before flipping.
              state_next     = ST_DWELL;
              dwell_cnt_next = '0;
            end else begin
              setpoint_next = leg_value;
              if (leg_opposing) begin
                if (leg_value == '0) begin
                  state_next     = (target_reg == '0) ? ST_IDLE : ST_DWELL;
                  dwell_cnt_next = '0;
                end
              end else if (leg_value == target_reg) begin
                state_next = ST_IDLE;
              end
            end
          end
        end

        ST_DWELL: begin
          setpoint_next = '0;
          if (capture && (bus.i_target == '0)) begin
            state_next     = ST_IDLE;
            dwell_cnt_next = '0;
          end else if (capture && (bus.i_target[31] == dir_reg)) begin
            // Target swung back to the current direction: no flip needed.
            state_next     = ST_RAMP;
            dwell_cnt_next = '0;
          end else if (tick) begin
            if (dwell_cnt_reg == DWELL_LAST) begin
              dir_next       = target_reg[31];
              state_next     = ST_RAMP;
              dwell_cnt_next = '0;
            end else begin
              dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
            end
          end
        end

        default: begin
          state_next    = ST_IDLE;
          setpoint_next = '0;
        end
      endcase
    end

    busy_next      = (state_next != ST_IDLE);
    at_target_next = (setpoint_next == target_next) && (state_next != ST_DWELL);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg     <= ST_IDLE;
      setpoint_reg  <= '0;
      target_reg    <= '0;
      dir_reg       <= 1'b0;
      motor_en_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      at_target_reg <= 1'b1;
      tick_cnt_reg  <= '0;
      dwell_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      setpoint_reg  <= setpoint_next;
      target_reg    <= target_next;
      dir_reg       <= dir_next;
      motor_en_reg  <= bus.i_enable;
      busy_reg      <= busy_next;
      at_target_reg <= at_target_next;
      tick_cnt_reg  <= tick_cnt_next;
      dwell_cnt_reg <= dwell_cnt_next;
    end
  end

  assign bus.o_setpoint  = setpoint_reg;
  assign bus.o_dir       = dir_reg;
  assign bus.o_motor_en  = motor_en_reg;
  assign bus.o_busy      = busy_reg;
  assign bus.o_at_target = at_target_reg;

endmodule

// File: tb/tb_setpoint_ramp.sv
// tb_setpoint_ramp
// Directed vector table for setpoint_ramp with TICK_CYCLES=4, DWELL_TICKS=2,
// plus hand-written reset sequences. One line per vector.
module tb_setpoint_ramp;

  typedef struct {
    logic        en;
    logic        vld;
    logic [31:0] tgt;
    logic [15:0] stp;
    int          edges;   // clock edges after applying inputs (first samples them)
    logic [31:0] e_sp;
    logic        e_dir;
    logic        e_men;
    logic        e_busy;
    logic        e_at;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  setpoint_ramp_if bus ();

  setpoint_ramp #(
    .TICK_CYCLES (4),
    .DWELL_TICKS (2)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] sp, input logic dir,
                         input logic men, input logic busy, input logic at);
    chk({tag, ".setpoint"},  bus.o_setpoint,        sp);
    chk({tag, ".dir"},       {31'd0, bus.o_dir},       {31'd0, dir});
    chk({tag, ".motor_en"},  {31'd0, bus.o_motor_en},  {31'd0, men});
    chk({tag, ".busy"},      {31'd0, bus.o_busy},      {31'd0, busy});
    chk({tag, ".at_target"}, {31'd0, bus.o_at_target}, {31'd0, at});
  endtask

  task automatic add(input logic en, input logic vld, input logic [31:0] tgt,
                     input logic [15:0] stp, input int edges, input logic [31:0] sp,
                     input logic dir, input logic men, input logic busy, input logic at);
    vec_t v;
    v.en = en; v.vld = vld; v.tgt = tgt; v.stp = stp; v.edges = edges;
    v.e_sp = sp; v.e_dir = dir; v.e_men = men; v.e_busy = busy; v.e_at = at;
    vecs.push_back(v);
  endtask

  task automatic tick_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      bus.i_target_valid = 1'b0;
    end
  endtask

  localparam logic [31:0] MIN = 32'h8000_0000;

  initial begin
    bus.i_enable       = 1'b0;
    bus.i_target       = '0;
    bus.i_target_valid = 1'b0;
    bus.i_step         = '0;

    // Ramp up 0 -> 250
    add(1, 0, 0,    100, 1, 0,   0, 1, 0, 1);
    add(1, 1, 250,  100, 1, 0,   0, 1, 1, 0);
    add(1, 0, 0,    100, 3, 0,   0, 1, 1, 0);
    add(1, 0, 0,    100, 1, 100, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 200, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 250, 0, 1, 0, 1);
    // Reversal 250 -> -150 through a two-tick dwell
    add(1, 1, -150, 100, 1, 250, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 150, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 50,  0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 0,   0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 0,   0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 0,   1, 1, 1, 0);
    add(1, 0, 0,    100, 4, -100, 1, 1, 1, 0);
    add(1, 0, 0,    100, 4, -150, 1, 1, 0, 1);
    // Reversal toward +100, aborted in dwell by a capture of -80
    add(1, 1, 100,  100, 1, -150, 1, 1, 1, 0);
    add(1, 0, 0,    100, 4, -50, 1, 1, 1, 0);
    add(1, 0, 0,    100, 4, 0,   1, 1, 1, 0);
    add(1, 0, 0,    100, 2, 0,   1, 1, 1, 0);
    add(1, 1, -80,  100, 1, 0,   1, 1, 1, 0);
    add(1, 0, 0,    100, 1, -80, 1, 1, 0, 1);
    // Back to zero, then disable mid-ramp
    add(1, 1, 0,    100, 1, -80, 1, 1, 1, 0);
    add(1, 0, 0,    100, 4, 0,   1, 1, 0, 1);
    add(1, 1, 250,  100, 1, 0,   0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 100, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 200, 0, 1, 1, 0);
    add(0, 0, 0,    100, 1, 0,   0, 0, 0, 0);
    add(0, 1, 0,    100, 1, 0,   0, 0, 0, 0);   // strobe ignored while disabled
    add(1, 0, 0,    100, 8, 0,   0, 1, 0, 0);   // no ramp without a new capture
    add(1, 1, 300,  100, 5, 100, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 200, 0, 1, 1, 0);
    add(1, 0, 0,    100, 4, 300, 0, 1, 0, 1);
    // Extremes: jump near -2^31, then 0xFFFF steps to exactly 0x80000000
    add(0, 0, 0,    0,   1, 0,   0, 0, 0, 0);
    add(1, 1, MIN + 32'd196705, 0, 1, 0, 1, 1, 1, 0);
    add(1, 0, 0,    0,   3, 0,   1, 1, 1, 0);
    add(1, 0, 0,    0,   1, MIN + 32'd196705, 1, 1, 0, 1);
    add(1, 1, MIN,  16'hFFFF, 5, MIN + 32'd131170, 1, 1, 1, 0);
    add(1, 0, 0,    16'hFFFF, 4, MIN + 32'd65635,  1, 1, 1, 0);
    add(1, 0, 0,    16'hFFFF, 4, MIN + 32'd100,    1, 1, 1, 0);
    add(1, 0, 0,    16'hFFFF, 4, MIN,              1, 1, 0, 1);
    // Bypass: step 0 jumps to 500 in one tick
    add(0, 0, 0,    0,   1, 0,   1, 0, 0, 0);
    add(1, 1, 500,  0,   1, 0,   0, 1, 1, 0);
    add(1, 0, 0,    0,   4, 500, 0, 1, 0, 1);

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick_edges(1);
    chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("vec reset sp=%0d dir=%0b men=%0b busy=%0b at=%0b", $signed(bus.o_setpoint),
             bus.o_dir, bus.o_motor_en, bus.o_busy, bus.o_at_target);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.i_enable       = vecs[i].en;
      bus.i_target_valid = vecs[i].vld;
      bus.i_target       = vecs[i].tgt;
      bus.i_step         = vecs[i].stp;
      tick_edges(vecs[i].edges);
      chk_all($sformatf("v%0d", i), vecs[i].e_sp, vecs[i].e_dir, vecs[i].e_men,
              vecs[i].e_busy, vecs[i].e_at);
      $display("vec %0d en=%0b vld=%0b tgt=%0d step=%0d -> sp=%0d dir=%0b men=%0b busy=%0b at=%0b",
               i, vecs[i].en, vecs[i].vld, $signed(vecs[i].tgt), vecs[i].stp,
               $signed(bus.o_setpoint), bus.o_dir, bus.o_motor_en, bus.o_busy, bus.o_at_target);
    end

    // Asynchronous reset mid-ramp toward -1000 (dir is 1 beforehand)
    bus.i_enable = 1'b0;
    tick_edges(1);
    bus.i_enable       = 1'b1;
    bus.i_target_valid = 1'b1;
    bus.i_target       = -32'sd1000;
    bus.i_step         = 16'd100;
    tick_edges(5);
    chk_all("pre_rst", -32'sd100, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    rstn = 1'b0;
    #1;
    chk_all("async_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("vec async_rst sp=%0d dir=%0b men=%0b busy=%0b at=%0b", $signed(bus.o_setpoint),
             bus.o_dir, bus.o_motor_en, bus.o_busy, bus.o_at_target);
    tick_edges(2);
    chk_all("in_rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
